tl_ctrl: RTL and testbench

- Traffic-light control FSM; sits directly upstream of the timing datapath, dp.
- Drives the one-hot `curr_state` and the `dp_cnt_rst` pulse into dp.
- Consumes dp's sticky `done_state` flags and sequences one light cycle: G1 → NONE1 → G2 → NONE2 → G3 → Y → R.
- Issues `red_done` at the end of each cycle so dp can clear its flags; also drives the lamps, a cycle counter and a phase watchdog.

---
 rtl/tl_ctrl.sv | 91 +++++++++
 tb/tb_tl_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ctrl.sv
// tl_ctrl: traffic-light phase sequencer with registered lamp/dp outputs, cycle counter and per-phase watchdog
module tl_ctrl #(
   parameter int STATE_W      = 4,
   parameter int STATE_DONE_W = 7,
   parameter int TIMEOUT      = 2048,
   parameter int WD_W         = 12
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [STATE_DONE_W-1:0] done_state,
   output logic [STATE_W-1:0]      curr_state,
   output logic                    dp_cnt_rst,
   output logic                    red_done,
   output logic                    light_g,
   output logic                    light_y,
   output logic                    light_r,
   output logic [7:0]              cycle_cnt,
   output logic                    fault
);
   localparam int S_G = 0, S_Y = 1, S_R = 2, S_NONE = 3;
   localparam int DONE_G1 = 0, DONE_G2 = 1, DONE_G3 = 2, DONE_Y = 3, DONE_R = 4, DONE_NONE1 = 5, DONE_NONE2 = 6;

   typedef enum logic [3:0] {IDLE, G1, NONE1, G2, NONE2, G3, Y, R, FLT} phase_t;

   phase_t             phase, phase_nxt;
   logic [WD_W-1:0]    wd, wd_nxt;
   logic               exit_hit, timeout_hit, red_exit, hold_rst;
   logic [STATE_W-1:0] state_nxt;
   logic               rst_nxt, g_nxt, y_nxt, r_nxt;

   always_ff @(posedge clk)
      if (!reset) begin
         phase      <= IDLE;
         wd         <= '0;
         curr_state <= '0;
         dp_cnt_rst <= 1'b1;
         red_done   <= 1'b0;
         light_g    <= 1'b0;
         light_y    <= 1'b0;
         light_r    <= 1'b0;
         cycle_cnt  <= '0;
         fault      <= 1'b0;
      end else begin
         phase      <= phase_nxt;
         wd         <= wd_nxt;
         curr_state <= state_nxt;
         dp_cnt_rst <= rst_nxt;
         red_done   <= red_exit;
         light_g    <= g_nxt;
         light_y    <= y_nxt;
         light_r    <= r_nxt;
         cycle_cnt  <= cycle_cnt + 8'(red_exit);
         fault      <= phase_nxt == FLT;
      end

   // Only the current phase's own done bit is looked at, so stale flags cannot skip a phase.
   always_comb begin
      exit_hit  = 1'b0;
      phase_nxt = phase;
      case (phase)
         IDLE:  phase_nxt = enable ? G1 : IDLE;
         G1:    begin exit_hit = done_state[DONE_G1];    phase_nxt = exit_hit ? NONE1 : G1;    end
         NONE1: begin exit_hit = done_state[DONE_NONE1]; phase_nxt = exit_hit ? G2 : NONE1;    end
         G2:    begin exit_hit = done_state[DONE_G2];    phase_nxt = exit_hit ? NONE2 : G2;    end
         NONE2: begin exit_hit = done_state[DONE_NONE2]; phase_nxt = exit_hit ? G3 : NONE2;    end
         G3:    begin exit_hit = done_state[DONE_G3];    phase_nxt = exit_hit ? Y : G3;        end
         Y:     begin exit_hit = done_state[DONE_Y];     phase_nxt = exit_hit ? R : Y;         end
         R:     begin exit_hit = done_state[DONE_R];     phase_nxt = !exit_hit ? R : enable ? G1 : IDLE; end
         default: phase_nxt = FLT;
      endcase
      timeout_hit = phase != IDLE && phase != FLT && wd == WD_W'(TIMEOUT);
      if (timeout_hit && !exit_hit) phase_nxt = FLT;
   end

   // Outputs are decoded from the next phase so they land in the same cycle as the phase change.
   always_comb begin
      hold_rst  = phase_nxt == IDLE || phase_nxt == FLT;
      rst_nxt   = phase_nxt != phase || hold_rst;
      wd_nxt    = rst_nxt ? '0 : wd + WD_W'(1);
      red_exit  = phase == R && exit_hit;
      g_nxt     = phase_nxt inside {G1, G2, G3};
      y_nxt     = phase_nxt == Y;
      r_nxt     = phase_nxt inside {R, FLT};
      state_nxt = '0;
      state_nxt[S_G]    = g_nxt;
      state_nxt[S_Y]    = y_nxt;
      state_nxt[S_R]    = r_nxt;
      state_nxt[S_NONE] = phase_nxt inside {NONE1, NONE2};
   end
endmodule

// File: tb/tb_tl_ctrl.sv
// tb_tl_ctrl: bench for tl_ctrl; a default-timeout instance with a dp model and a short-timeout instance for the watchdog.
module tb_tl_ctrl;
   localparam logic [3:0] SG = 4'b0001, SY = 4'b0010, SR = 4'b0100, SN = 4'b1000;

   logic clk = 1'b0, reset = 1'b0, reset2 = 1'b0, enable = 1'b1;
   logic [6:0] done = '0, done2 = '0;
   logic [3:0] cs, cs2;
   logic rst, rd, lg, ly, lr, flt, rst2, rd2, lg2, ly2, lr2, flt2;
   logic [7:0] cnt, cnt2;
   int checks = 0, errors = 0;

   typedef struct {logic [3:0] cs; logic rd; logic [7:0] cnt;} exp_t;
   exp_t q[$];
   logic [7:0] cnt_q[$];
   int dp_cnt;
   logic [6:0] flags;

   tl_ctrl u_dut (.clk(clk), .reset(reset), .enable(enable), .done_state(done), .curr_state(cs),
      .dp_cnt_rst(rst), .red_done(rd), .light_g(lg), .light_y(ly), .light_r(lr), .cycle_cnt(cnt), .fault(flt));

   tl_ctrl #(.TIMEOUT(16), .WD_W(5)) u_wd (.clk(clk), .reset(reset2), .enable(enable), .done_state(done2),
      .curr_state(cs2), .dp_cnt_rst(rst2), .red_done(rd2), .light_g(lg2), .light_y(ly2), .light_r(lr2),
      .cycle_cnt(cnt2), .fault(flt2));

   always #5 clk = ~clk;

   function automatic logic [2:0] lamps(input logic [3:0] s);
      return {s[2], s[1], s[0]};
   endfunction

   // dp model: cycle counter cleared by dp_cnt_rst, sticky flags cleared by red_done
   task automatic dp_update();
      int thr, b;
      thr = 0;
      b = -1;
      if (rd) flags = '0;
      dp_cnt = rst ? 0 : dp_cnt + 1;
      case (cs)
         SG: begin b = !flags[0] ? 0 : !flags[1] ? 1 : 2; thr = b == 0 ? 1024 : 128; end
         SN: begin b = !flags[5] ? 5 : 6; thr = 128; end
         SY: begin b = 3; thr = 512; end
         SR: begin b = 4; thr = 1024; end
         default: b = -1;
      endcase
      if (b >= 0 && dp_cnt >= thr - 1) flags[b] = 1'b1;
      done = flags;
   endtask

   task automatic drive_phase(input int bitn, input logic [3:0] cur, input logic [3:0] nxt, input logic nrd, input string nm);
      done = '0;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({cs, rst, rd, lr, ly, lg} !== {cur, 1'b0, 1'b0, lamps(cur)}) begin
            errors++;
            $display("FAIL %s hold: got %b expected %b", nm, {cs, rst, rd, lr, ly, lg}, {cur, 1'b0, 1'b0, lamps(cur)});
         end
      end
      done = 7'(1) << bitn;
      @(negedge clk);
      checks++;
      if ({cs, rst, rd, lr, ly, lg} !== {nxt, 1'b1, nrd, lamps(nxt)}) begin
         errors++;
         $display("FAIL %s exit: got %b expected %b", nm, {cs, rst, rd, lr, ly, lg}, {nxt, 1'b1, nrd, lamps(nxt)});
      end
      done = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      enable = 1'b1;
      done = '0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({cs, rst, rd, lr, ly, lg, cnt, flt} !== {4'b0, 1'b1, 1'b0, 3'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", {cs, rst, rd, lr, ly, lg, cnt, flt}, {4'b0, 1'b1, 1'b0, 3'b0, 8'd0, 1'b0});
         end
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({cs, rst, lr, ly, lg} !== {SG, 1'b1, 3'b001}) begin
         errors++;
         $display("FAIL release_g1: got %b expected %b", {cs, rst, lr, ly, lg}, {SG, 1'b1, 3'b001});
      end
      @(negedge clk);
      checks++;
      if ({cs, rst, lr, ly, lg} !== {SG, 1'b0, 3'b001}) begin
         errors++;
         $display("FAIL rst_pulse_width: got %b expected %b", {cs, rst, lr, ly, lg}, {SG, 1'b0, 3'b001});
      end
   endtask

   task automatic test_full_cycle();
      exp_t e;
      int rd_seen;
      logic [3:0] order[8] = '{SG, SN, SG, SN, SG, SY, SR, SG};
      reset = 1'b0;
      done = '0;
      flags = '0;
      dp_cnt = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) q.push_back('{order[i], i == 7, i == 7 ? 8'd1 : 8'd0});
      rd_seen = 0;
      for (int i = 0; i < 6000 && q.size() > 0; i++) begin
         @(negedge clk);
         if (rd) rd_seen++;
         if (rst) begin
            e = q.pop_front();
            checks++;
            if ({cs, rd, cnt, lr, ly, lg} !== {e.cs, e.rd, e.cnt, lamps(e.cs)}) begin
               errors++;
               $display("FAIL cycle_entry: got %b expected %b", {cs, rd, cnt, lr, ly, lg}, {e.cs, e.rd, e.cnt, lamps(e.cs)});
            end
         end
         dp_update();
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL cycle_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
      checks++;
      if (rd_seen != 1) begin
         errors++;
         $display("FAIL red_done_count: got %0d expected 1", rd_seen);
      end
   endtask

   task automatic test_stale_flags();
      done = 7'b0000001;
      @(negedge clk);
      checks++;
      if ({cs, rst} !== {SN, 1'b1}) begin
         errors++;
         $display("FAIL none1_entry: got %b expected %b", {cs, rst}, {SN, 1'b1});
      end
      done = 7'b0001001;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if ({cs, rst} !== {SN, 1'b0}) begin
            errors++;
            $display("FAIL stale_hold: got %b expected %b", {cs, rst}, {SN, 1'b0});
         end
      end
      done = 7'b0101001;
      @(negedge clk);
      checks++;
      if ({cs, rst, lg} !== {SG, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL g2_entry: got %b expected %b", {cs, rst, lg}, {SG, 1'b1, 1'b1});
      end
      done = '0;
   endtask

   task automatic test_enable_drop();
      enable = 1'b0;
      drive_phase(1, SG, SN, 1'b0, "g2");
      drive_phase(6, SN, SG, 1'b0, "none2");
      drive_phase(2, SG, SY, 1'b0, "g3");
      drive_phase(3, SY, SR, 1'b0, "y");
      drive_phase(4, SR, 4'b0, 1'b1, "r_to_idle");
      checks++;
      if (cnt !== 8'd2) begin
         errors++;
         $display("FAIL idle_cycle_cnt: got %0d expected 2", cnt);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({cs, rst, rd, lr, ly, lg} !== {4'b0, 1'b1, 1'b0, 3'b0}) begin
            errors++;
            $display("FAIL idle_hold: got %b expected %b", {cs, rst, rd, lr, ly, lg}, {4'b0, 1'b1, 1'b0, 3'b0});
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] ev;
      reset = 1'b0;
      done = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      enable = 1'b1;
      done = 7'h7f;
      for (int k = 1; k <= 256; k++) cnt_q.push_back(8'(k));
      for (int i = 0; i < 256 * 7 + 40 && cnt_q.size() > 0; i++) begin
         @(negedge clk);
         if (rd) begin
            ev = cnt_q.pop_front();
            checks++;
            if ({cnt, cs} !== {ev, SG}) begin
               errors++;
               $display("FAIL wrap_cnt: got %0d/%b expected %0d/%b", cnt, cs, ev, SG);
            end
         end
      end
      done = '0;
      checks++;
      if (cnt_q.size() != 0 || cnt !== 8'd0) begin
         errors++;
         $display("FAIL wrap_final: got %0d pending cnt %0d expected 0 pending cnt 0", cnt_q.size(), cnt);
         cnt_q.delete();
      end
   endtask

   task automatic test_watchdog();
      logic found;
      @(negedge clk);
      checks++;
      if ({cs2, rst2, flt2} !== {4'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL wd_reset: got %b expected %b", {cs2, rst2, flt2}, {4'b0, 1'b1, 1'b0});
      end
      done2 = 7'b1100111;
      reset2 = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = cs2 == SY;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wd_reach_y: got %b expected %b", cs2, SY);
      end
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         checks++;
         if ({cs2, flt2} !== {SY, 1'b0}) begin
            errors++;
            $display("FAIL wd_y_hold %0d: got %b expected %b", k, {cs2, flt2}, {SY, 1'b0});
         end
      end
      @(negedge clk);
      checks++;
      if ({cs2, rst2, rd2, lr2, ly2, lg2, flt2} !== {SR, 1'b1, 1'b0, 3'b100, 1'b1}) begin
         errors++;
         $display("FAIL wd_fault: got %b expected %b", {cs2, rst2, rd2, lr2, ly2, lg2, flt2}, {SR, 1'b1, 1'b0, 3'b100, 1'b1});
      end
      done2 = 7'h7f;
      repeat (100) @(negedge clk);
      checks++;
      if ({cs2, rst2, rd2, lr2, ly2, lg2, flt2} !== {SR, 1'b1, 1'b0, 3'b100, 1'b1}) begin
         errors++;
         $display("FAIL wd_fault_sticky: got %b expected %b", {cs2, rst2, rd2, lr2, ly2, lg2, flt2}, {SR, 1'b1, 1'b0, 3'b100, 1'b1});
      end
      reset2 = 1'b0;
      @(negedge clk);
      checks++;
      if ({cs2, rst2, lr2, ly2, lg2, flt2} !== {4'b0, 1'b1, 3'b0, 1'b0}) begin
         errors++;
         $display("FAIL wd_fault_reset: got %b expected %b", {cs2, rst2, lr2, ly2, lg2, flt2}, {4'b0, 1'b1, 3'b0, 1'b0});
      end
   endtask

   task automatic test_exit_wins();
      logic found;
      done2 = 7'b1101111;
      reset2 = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = cs2 == SR;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL ew_reach_r: got %b expected %b", cs2, SR);
      end
      repeat (16) @(negedge clk);
      checks++;
      if ({cs2, flt2} !== {SR, 1'b0}) begin
         errors++;
         $display("FAIL ew_r_hold: got %b expected %b", {cs2, flt2}, {SR, 1'b0});
      end
      done2 = 7'h7f;
      @(negedge clk);
      checks++;
      if ({cs2, rst2, rd2, flt2, cnt2} !== {SG, 1'b1, 1'b1, 1'b0, 8'd1}) begin
         errors++;
         $display("FAIL exit_wins: got %b expected %b", {cs2, rst2, rd2, flt2, cnt2}, {SG, 1'b1, 1'b1, 1'b0, 8'd1});
      end
      done2 = '0;
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_full_cycle();
      test_stale_flags();
      test_enable_drop();
      test_wrap();
      test_watchdog();
      test_exit_wins();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
